// File: rtl/dsi_pkt_arbiter.sv
// Shares the packet assembler port between the video timing generator (priority)
// and the host command path, with atomic grants, a guard gap and a grant watchdog.
module dsi_pkt_arbiter #(
  parameter int g_pixel_width  = 24,
  parameter int g_guard_cycles = 4,
  parameter int g_timeout      = 4095
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic                     v_req_i,
  input  logic                     v_islong_i,
  input  logic [5:0]               v_type_i,
  input  logic [15:0]              v_wcount_i,
  input  logic [15:0]              v_command_i,
  input  logic [g_pixel_width-1:0] v_payload_i,
  input  logic                     v_last_i,
  output logic                     v_dreq_o,
  input  logic                     v_blank_i,

  input  logic                     h_req_i,
  input  logic                     h_islong_i,
  input  logic [5:0]               h_type_i,
  input  logic [15:0]              h_wcount_i,
  input  logic [15:0]              h_command_i,
  input  logic [g_pixel_width-1:0] h_payload_i,
  input  logic                     h_last_i,
  output logic                     h_dreq_o,

  output logic                     p_req_o,
  output logic                     p_islong_o,
  output logic [5:0]               p_type_o,
  output logic [15:0]              p_wcount_o,
  output logic [15:0]              p_command_o,
  output logic [g_pixel_width-1:0] p_payload_o,
  output logic                     p_last_o,
  input  logic                     p_dreq_i,
  input  logic                     p_dlast_i,

  output logic [1:0]               gnt_o,
  output logic [15:0]              h_cnt_o,
  output logic                     err_timeout_o,
  output logic                     err_abort_o,
  input  logic                     err_clr_i
);

  localparam int          c_guard      = (g_guard_cycles < 1) ? 1 : g_guard_cycles;
  localparam logic [15:0] c_guard_last = 16'(c_guard - 1);
  localparam logic [11:0] c_wd_last    = 12'(g_timeout - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VIDEO,
    ST_HOST,
    ST_GUARD
  } state_t;

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic [15:0] r_gc;
  logic [11:0] r_wd;
  logic [15:0] r_hcnt;
  logic        r_err_to;
  logic        r_err_ab;

  logic        w_own_req;
  logic        w_host_ok;

  assign w_host_ok = h_req_i & v_blank_i;

  // The last guard cycle arbitrates like IDLE so the next grant can follow the gap directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 2'b00;
      r_gc     <= '0;
      r_wd     <= '0;
      r_hcnt   <= '0;
      r_err_to <= 1'b0;
      r_err_ab <= 1'b0;
    end else begin
      if (err_clr_i) begin
        r_err_to <= 1'b0;
        r_err_ab <= 1'b0;
      end
      case (r_state)
        ST_VIDEO, ST_HOST: begin
          r_wd <= r_wd + 12'd1;
          if (p_dlast_i || !w_own_req || (r_wd == c_wd_last)) begin
            r_state <= ST_GUARD;
            r_gnt   <= 2'b00;
            r_gc    <= c_guard_last;
          end
          if (p_dlast_i) begin
            if (r_state == ST_HOST) r_hcnt <= r_hcnt + 16'd1;
          end else if (!w_own_req) begin
            r_err_ab <= 1'b1;
          end else if (r_wd == c_wd_last) begin
            r_err_to <= 1'b1;
          end
        end
        default: begin
          if ((r_state == ST_GUARD) && (r_gc != 16'd0)) begin
            r_gc <= r_gc - 16'd1;
          end else if (v_req_i) begin
            r_state <= ST_VIDEO;
            r_gnt   <= 2'b01;
            r_wd    <= '0;
          end else if (w_host_ok) begin
            r_state <= ST_HOST;
            r_gnt   <= 2'b10;
            r_wd    <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_own_req   = 1'b0;
    p_req_o     = 1'b0;
    p_islong_o  = 1'b0;
    p_type_o    = '0;
    p_wcount_o  = '0;
    p_command_o = '0;
    p_payload_o = '0;
    p_last_o    = 1'b0;
    v_dreq_o    = 1'b0;
    h_dreq_o    = 1'b0;
    case (r_state)
      ST_VIDEO: begin
        w_own_req   = v_req_i;
        p_req_o     = v_req_i;
        p_islong_o  = v_islong_i;
        p_type_o    = v_type_i;
        p_wcount_o  = v_wcount_i;
        p_command_o = v_command_i;
        p_payload_o = v_payload_i;
        p_last_o    = v_last_i;
        v_dreq_o    = p_dreq_i;
      end
      ST_HOST: begin
        w_own_req   = h_req_i;
        p_req_o     = h_req_i;
        p_islong_o  = h_islong_i;
        p_type_o    = h_type_i;
        p_wcount_o  = h_wcount_i;
        p_command_o = h_command_i;
        p_payload_o = h_payload_i;
        p_last_o    = h_last_i;
        h_dreq_o    = p_dreq_i;
      end
      default: begin
      end
    endcase
  end

  assign gnt_o         = r_gnt;
  assign h_cnt_o       = r_hcnt;
  assign err_timeout_o = r_err_to;
  assign err_abort_o   = r_err_ab;

endmodule

// File: tb/tb_dsi_pkt_arbiter.sv
// Bench for dsi_pkt_arbiter: directed scenarios followed by a random phase, every
// cycle compared against a cycle-counting reference model of the arbitration rules.
module tb_dsi_pkt_arbiter;

  localparam int W       = 24;
  localparam int TIMEOUT = 20;
  localparam int GAP     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          v_req = 0, v_islong = 0, v_last = 0, v_blank = 0;
  logic [5:0]    v_type = 0;
  logic [15:0]   v_wcount = 0, v_command = 0;
  logic [W-1:0]  v_payload = 0;
  logic          h_req = 0, h_islong = 0, h_last = 0;
  logic [5:0]    h_type = 0;
  logic [15:0]   h_wcount = 0, h_command = 0;
  logic [W-1:0]  h_payload = 0;
  logic          p_dreq = 0, p_dlast = 0, err_clr = 0;

  logic          v_dreq_o, h_dreq_o, p_req_o, p_islong_o, p_last_o;
  logic [5:0]    p_type_o;
  logic [15:0]   p_wcount_o, p_command_o, h_cnt_o;
  logic [W-1:0]  p_payload_o;
  logic [1:0]    gnt_o;
  logic          err_timeout_o, err_abort_o;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: owner (-1 none, 0 video, 1 host), grant start cycle,
  // earliest cycle at which a new request may be sampled.
  int          cyc     = 0;
  int          m_owner = -1;
  int          m_start = 0;
  int          m_ready = 0;
  logic [15:0] m_hcnt  = 0;
  logic        m_errTo = 0;
  logic        m_errAb = 0;

  dsi_pkt_arbiter #(
    .g_pixel_width (W),
    .g_guard_cycles(GAP),
    .g_timeout     (TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .v_req_i      (v_req),
    .v_islong_i   (v_islong),
    .v_type_i     (v_type),
    .v_wcount_i   (v_wcount),
    .v_command_i  (v_command),
    .v_payload_i  (v_payload),
    .v_last_i     (v_last),
    .v_dreq_o     (v_dreq_o),
    .v_blank_i    (v_blank),
    .h_req_i      (h_req),
    .h_islong_i   (h_islong),
    .h_type_i     (h_type),
    .h_wcount_i   (h_wcount),
    .h_command_i  (h_command),
    .h_payload_i  (h_payload),
    .h_last_i     (h_last),
    .h_dreq_o     (h_dreq_o),
    .p_req_o      (p_req_o),
    .p_islong_o   (p_islong_o),
    .p_type_o     (p_type_o),
    .p_wcount_o   (p_wcount_o),
    .p_command_o  (p_command_o),
    .p_payload_o  (p_payload_o),
    .p_last_o     (p_last_o),
    .p_dreq_i     (p_dreq),
    .p_dlast_i    (p_dlast),
    .gnt_o        (gnt_o),
    .h_cnt_o      (h_cnt_o),
    .err_timeout_o(err_timeout_o),
    .err_abort_o  (err_abort_o),
    .err_clr_i    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected outputs for the current cycle, derived from who owns the port.
  task automatic checkModel();
    logic [40:0]  expHdr;
    logic [W-1:0] expPay;
    logic [1:0]   expGnt;
    logic         expVd, expHd;
    expHdr = '0; expPay = '0; expGnt = 2'b00; expVd = 0; expHd = 0;
    if (m_owner == 0) begin
      expHdr = {v_req, v_islong, v_type, v_wcount, v_command, v_last};
      expPay = v_payload; expGnt = 2'b01; expVd = p_dreq;
    end else if (m_owner == 1) begin
      expHdr = {h_req, h_islong, h_type, h_wcount, h_command, h_last};
      expPay = h_payload; expGnt = 2'b10; expHd = p_dreq;
    end
    checkOutput("gnt", gnt_o, expGnt);
    checkOutput("p_hdr", {p_req_o, p_islong_o, p_type_o, p_wcount_o, p_command_o, p_last_o}, expHdr);
    checkOutput("p_payload", p_payload_o, expPay);
    checkOutput("v_dreq", v_dreq_o, expVd);
    checkOutput("h_dreq", h_dreq_o, expHd);
    checkOutput("h_cnt", h_cnt_o, m_hcnt);
    checkOutput("err_timeout", err_timeout_o, m_errTo);
    checkOutput("err_abort", err_abort_o, m_errAb);
  endtask

  task automatic modelStep();
    logic setTo, setAb, ownReq;
    if (rst) begin
      m_owner = -1; m_ready = 0; m_hcnt = 0; m_errTo = 0; m_errAb = 0;
    end else begin
      setTo = 0; setAb = 0;
      if (m_owner >= 0) begin
        ownReq = (m_owner == 0) ? v_req : h_req;
        if (p_dlast) begin
          if (m_owner == 1) m_hcnt = m_hcnt + 16'd1;
        end else if (!ownReq) begin
          setAb = 1;
        end else if (cyc - m_start + 1 >= TIMEOUT) begin
          setTo = 1;
        end
        if (p_dlast || setAb || setTo) begin
          m_owner = -1;
          m_ready = cyc + GAP;
        end
      end else if (cyc >= m_ready) begin
        if (v_req) begin
          m_owner = 0; m_start = cyc + 1;
        end else if (h_req && v_blank) begin
          m_owner = 1; m_start = cyc + 1;
        end
      end
      m_errTo = setTo ? 1'b1 : (err_clr ? 1'b0 : m_errTo);
      m_errAb = setAb ? 1'b1 : (err_clr ? 1'b0 : m_errAb);
    end
  endtask

  // One clock cycle with the inputs as currently set: settle, compare, advance model and DUT.
  task automatic applyStimulus();
    #2;
    checkModel();
    modelStep();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    applyStimulus();
    applyStimulus();
    rst = 0;
    checkOutput("reset_gnt", gnt_o, 2'b00);
    checkOutput("reset_hcnt", h_cnt_o, 16'd0);

    // Simultaneous requests: video wins, host follows after the guard gap.
    v_req = 1; h_req = 1; v_blank = 1; v_type = 6'h3E; v_command = 16'h1234;
    h_type = 6'h05; h_command = 16'h0029;
    applyStimulus();
    checkOutput("sim_gnt_video", gnt_o, 2'b01);
    p_dlast = 1;
    applyStimulus();
    p_dlast = 0; v_req = 0;
    repeat (3) applyStimulus();
    checkOutput("sim_gap_gnt", gnt_o, 2'b00);
    applyStimulus();
    checkOutput("sim_gnt_host", gnt_o, 2'b10);
    p_dlast = 1;
    applyStimulus();
    p_dlast = 0; h_req = 0;
    checkOutput("sim_hcnt", h_cnt_o, 16'd1);

    // No blanking window: host waits, then is granted one cycle after blank rises.
    v_blank = 0; h_req = 1;
    repeat (100) applyStimulus();
    checkOutput("noblank_gnt", gnt_o, 2'b00);
    v_blank = 1;
    applyStimulus();
    checkOutput("blank_gnt_host", gnt_o, 2'b10);

    // No preemption: host long packet of 3 words while video requests mid-packet.
    h_islong = 1; h_wcount = 16'd6; h_type = 6'h39;
    p_dreq = 1; h_payload = 24'hA1A2A3;
    applyStimulus();
    v_req = 1; v_blank = 0; h_payload = 24'hB1B2B3; v_payload = 24'h555555;
    applyStimulus();
    checkOutput("nopre_gnt", gnt_o, 2'b10);
    checkOutput("nopre_vdreq", v_dreq_o, 1'b0);
    h_payload = 24'hC1C2C3; h_last = 1; p_dlast = 1;
    applyStimulus();
    p_dreq = 0; p_dlast = 0; h_last = 0; h_req = 0; h_islong = 0;
    repeat (3) applyStimulus();
    checkOutput("nopre_gap_gnt", gnt_o, 2'b00);
    applyStimulus();
    checkOutput("nopre_video_gnt", gnt_o, 2'b01);
    checkOutput("nopre_hcnt", h_cnt_o, 16'd2);
    p_dlast = 1;
    applyStimulus();
    p_dlast = 0; v_req = 0;

    // Watchdog: grant lasts exactly TIMEOUT cycles, flag sticky until cleared.
    repeat (5) applyStimulus();
    v_req = 1;
    applyStimulus();
    repeat (TIMEOUT - 1) applyStimulus();
    checkOutput("wd_still_gnt", gnt_o, 2'b01);
    checkOutput("wd_not_yet", err_timeout_o, 1'b0);
    applyStimulus();
    checkOutput("wd_gnt_drop", gnt_o, 2'b00);
    checkOutput("wd_flag", err_timeout_o, 1'b1);
    v_req = 0;
    repeat (3) applyStimulus();
    checkOutput("wd_sticky", err_timeout_o, 1'b1);
    err_clr = 1;
    applyStimulus();
    err_clr = 0;
    checkOutput("wd_cleared", err_timeout_o, 1'b0);
    repeat (2) applyStimulus();
    v_req = 1;
    applyStimulus();
    repeat (TIMEOUT - 1) applyStimulus();
    err_clr = 1;
    applyStimulus();
    err_clr = 0; v_req = 0;
    checkOutput("wd_set_beats_clr", err_timeout_o, 1'b1);

    // Abort: host drops its request mid-packet.
    repeat (5) applyStimulus();
    h_req = 1; v_blank = 1;
    applyStimulus();
    checkOutput("abort_gnt", gnt_o, 2'b10);
    h_req = 0;
    applyStimulus();
    checkOutput("abort_flag", err_abort_o, 1'b1);
    checkOutput("abort_hcnt", h_cnt_o, 16'd2);
    checkOutput("abort_gnt_drop", gnt_o, 2'b00);

    // Counter wrap from 0xFFFF.
    repeat (5) applyStimulus();
    force dut.r_hcnt = 16'hFFFF;
    #1;
    release dut.r_hcnt;
    m_hcnt = 16'hFFFF;
    h_req = 1;
    applyStimulus();
    p_dlast = 1;
    applyStimulus();
    p_dlast = 0; h_req = 0;
    checkOutput("wrap_hcnt", h_cnt_o, 16'h0000);

    // Reset in the middle of a video packet.
    repeat (5) applyStimulus();
    v_req = 1;
    applyStimulus();
    checkOutput("rst_pre_gnt", gnt_o, 2'b01);
    p_dreq = 1; rst = 1;
    applyStimulus();
    checkOutput("rst_p_req", p_req_o, 1'b0);
    checkOutput("rst_v_dreq", v_dreq_o, 1'b0);
    checkOutput("rst_gnt", gnt_o, 2'b00);
    checkOutput("rst_err_clear", {err_timeout_o, err_abort_o}, 2'b00);
    rst = 0;
    applyStimulus();
    checkOutput("rst_regrant", gnt_o, 2'b01);
    checkOutput("rst_regrant_req", p_req_o, 1'b1);
    v_req = 0; p_dreq = 0;
    applyStimulus();

    // Random phase against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) v_req = ~v_req;
      if ($urandom_range(7) == 0) h_req = ~h_req;
      if ($urandom_range(5) == 0) v_blank = ~v_blank;
      v_islong  = 1'($urandom);
      h_islong  = 1'($urandom);
      v_type    = 6'($urandom);
      h_type    = 6'($urandom);
      v_wcount  = 16'($urandom);
      h_wcount  = 16'($urandom);
      v_command = 16'($urandom);
      h_command = 16'($urandom);
      v_payload = W'($urandom);
      h_payload = W'($urandom);
      v_last    = 1'($urandom);
      h_last    = 1'($urandom);
      p_dreq    = 1'($urandom);
      p_dlast   = ($urandom_range(9) == 0);
      err_clr   = ($urandom_range(15) == 0);
      rst       = ($urandom_range(299) == 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
